// File: rtl/updown_cnt_ctrl_pkg.sv
// updown_cnt_ctrl_pkg: shared types and constants for the counter block.
// Provides FSM state encodings and BCD digit limits used by the display path.
package updown_cnt_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

endpackage

// File: rtl/updown_cnt_ctrl_step.sv
// bcd_digit_step: one BCD digit of the up/down ripple chain.
// Ports: digit/down/cin in; next (stepped digit), cout (carry or borrow) out.
module bcd_digit_step
    import updown_cnt_ctrl_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       down,
    input  logic       cin,
    output logic [3:0] next,
    output logic       cout
);

    always_comb begin
        next = digit;
        cout = 1'b0;
        if (cin) begin
            if (down) begin
                if (digit == BCD_MIN) begin
                    next = BCD_MAX;
                    cout = 1'b1;
                end else begin
                    next = digit - 4'd1;
                end
            end else begin
                if (digit == BCD_MAX) begin
                    next = BCD_MIN;
                    cout = 1'b1;
                end else begin
                    next = digit + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/updown_cnt_ctrl.sv
// updown_cnt_ctrl: run/stop/clear FSM, tick divider and 4-digit BCD counter.
// Ports: clk, rst (async high), i_btn_run/clear/mode pulses in;
// o_time_1..o_time_1000 BCD digits, o_run, o_mode_down out.
// Build option: define CNT_SAT_EN to saturate at 9999/0000 instead of wrapping.
module updown_cnt_ctrl
    import updown_cnt_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_run,
    input  logic       i_btn_clear,
    input  logic       i_btn_mode,
    output logic [3:0] o_time_1,
    output logic [3:0] o_time_10,
    output logic [3:0] o_time_100,
    output logic [3:0] o_time_1000,
    output logic       o_run,
    output logic       o_mode_down
);

    localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    state_t               state;
    logic [DW-1:0]        div;
    logic [3:0][3:0]      digit;
    logic [3:0][3:0]      next_digit;
    logic [4:0]           carry;
    logic                 tick;
    logic                 step_ok;

    assign tick     = (state == ST_RUN) && (div == DIV_LAST);
    // The chain is always enabled; the result is only taken on a tick.
    assign carry[0] = 1'b1;

    for (genvar g = 0; g < 4; g++) begin : g_digit
        bcd_digit_step u_step (
            .digit (digit[g]),
            .down  (o_mode_down),
            .cin   (carry[g]),
            .next  (next_digit[g]),
            .cout  (carry[g+1])
        );
    end

`ifdef CNT_SAT_EN
    // A carry out of the top digit means the step would wrap: hold instead.
    assign step_ok = ~carry[4];
`else
    logic wrap_unused;
    assign wrap_unused = carry[4];
    assign step_ok     = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_STOP;
            div         <= '0;
            digit       <= '0;
            o_run       <= 1'b0;
            o_mode_down <= 1'b0;
        end else begin
            if (i_btn_mode) begin
                o_mode_down <= ~o_mode_down;
            end
            unique case (state)
                ST_STOP: begin
                    if (i_btn_clear) begin
                        state <= ST_CLEAR;
                    end else if (i_btn_run) begin
                        state <= ST_RUN;
                        o_run <= 1'b1;
                    end
                end
                ST_RUN: begin
                    div <= tick ? '0 : div + DW'(1);
                    if (tick && step_ok) begin
                        digit <= next_digit;
                    end
                    if (i_btn_run) begin
                        state <= ST_STOP;
                        o_run <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    digit <= '0;
                    div   <= '0;
                    state <= ST_STOP;
                end
                default: begin
                    state <= ST_STOP;
                    o_run <= 1'b0;
                end
            endcase
        end
    end

    assign o_time_1    = digit[0];
    assign o_time_10   = digit[1];
    assign o_time_100  = digit[2];
    assign o_time_1000 = digit[3];

endmodule

// File: tb/tb_updown_cnt_ctrl.sv
// tb_updown_cnt_ctrl: scoreboard bench for updown_cnt_ctrl with TICK_DIV = 4.
// A cycle model pushes expected outputs per driven cycle; tasks pop and compare.
module tb_updown_cnt_ctrl;

    localparam int TD = 4;

    typedef logic [17:0] obs_t;

    logic       clk;
    logic       rst;
    logic       btn_run;
    logic       btn_clear;
    logic       btn_mode;
    logic [3:0] t1, t10, t100, t1000;
    logic       run;
    logic       mode_down;

    int checks = 0;
    int errors = 0;

    int   m_cnt;
    int   m_div;
    int   m_st;
    logic m_mode;
    obs_t q[$];
    obs_t e;
    obs_t obs;

    assign obs = {t1000, t100, t10, t1, run, mode_down};

    updown_cnt_ctrl #(.TICK_DIV(TD)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_btn_run   (btn_run),
        .i_btn_clear (btn_clear),
        .i_btn_mode  (btn_mode),
        .o_time_1    (t1),
        .o_time_10   (t10),
        .o_time_100  (t100),
        .o_time_1000 (t1000),
        .o_run       (run),
        .o_mode_down (mode_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic obs_t m_out();
        return {bcd(m_cnt), m_st == 1, m_mode};
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_div  = 0;
        m_st   = 0;
        m_mode = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic c, input logic m);
        bit tick;
        bit sat;
        sat = 1'b0;
`ifdef CNT_SAT_EN
        sat = 1'b1;
`endif
        if (rst) begin
            model_reset();
            return;
        end
        tick = (m_st == 1) && (m_div == TD - 1);
        if (tick) begin
            if (!m_mode) m_cnt = (m_cnt == 9999) ? (sat ? 9999 : 0) : m_cnt + 1;
            else         m_cnt = (m_cnt == 0) ? (sat ? 0 : 9999) : m_cnt - 1;
        end
        case (m_st)
            0: begin
                if (c)      m_st = 2;
                else if (r) m_st = 1;
            end
            1: begin
                m_div = tick ? 0 : m_div + 1;
                if (r) m_st = 0;
            end
            default: begin
                m_cnt = 0;
                m_div = 0;
                m_st  = 0;
            end
        endcase
        if (m) m_mode = ~m_mode;
    endtask

    task automatic drive(input logic r, input logic c, input logic m);
        btn_run   = r;
        btn_clear = c;
        btn_mode  = m;
        model_step(r, c, m);
        q.push_back(m_out());
        @(posedge clk);
        #1;
        btn_run   = 1'b0;
        btn_clear = 1'b0;
        btn_mode  = 1'b0;
    endtask

    task automatic do_clear();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, i == 0, 1'b0);
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL clear cyc %0d got %h exp %h", i, obs, e);
            end
        end
    endtask

    task automatic goto_count(input int target, input logic down);
        bit   ran;
        bit   done;
        logic r;
        logic m;
        ran  = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 60000 && !done; n++) begin
            r = 1'b0;
            m = 1'b0;
            if (n == 0 && m_mode != down) begin
                m = 1'b1;
            end else if (!ran) begin
                r   = 1'b1;
                ran = 1'b1;
            end else if (m_cnt == target) begin
                r    = 1'b1;
                done = 1'b1;
            end
            drive(r, 1'b0, m);
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL goto %0d n %0d got %h exp %h", target, n, obs, e);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL goto_timeout got %0d exp %0d", m_cnt, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if (obs !== 18'h0) begin
            errors++;
            $display("FAIL reset got %h exp %h", obs, 18'h0);
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        e = q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_idle got %h exp %h", obs, e);
        end
    endtask

    task automatic test_run_count();
        for (int i = 0; i < 42; i++) begin
            drive(i == 0 || i == 41, 1'b0, 1'b0);
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL run_count cyc %0d got %h exp %h", i, obs, e);
            end
            if (i == 40) begin
                checks++;
                if (obs[17:1] !== {16'h0010, 1'b1}) begin
                    errors++;
                    $display("FAIL run_count_0010 got %h exp %h", obs[17:1], {16'h0010, 1'b1});
                end
            end
        end
    endtask

    task automatic test_wrap_up();
        logic [15:0] fin;
        do_clear();
`ifdef CNT_SAT_EN
        goto_count(9998, 1'b0);
        fin = 16'h9999;
`else
        goto_count(9998, 1'b1);
        fin = 16'h0000;
`endif
        for (int i = 0; i < 10; i++) begin
            drive(i == 1 || i == 9, 1'b0, i == 0 && m_mode);
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL wrap_up cyc %0d got %h exp %h", i, obs, e);
            end
        end
        checks++;
        if (obs[17:2] !== fin) begin
            errors++;
            $display("FAIL wrap_up_final got %h exp %h", obs[17:2], fin);
        end
    endtask

    task automatic test_wrap_down();
        logic [15:0] fin;
`ifdef CNT_SAT_EN
        fin = 16'h0000;
`else
        fin = 16'h9998;
`endif
        do_clear();
        for (int i = 0; i < 11; i++) begin
            drive(i == 1 || i == 10, 1'b0, i == 0 && !m_mode);
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL wrap_down cyc %0d got %h exp %h", i, obs, e);
            end
        end
        checks++;
        if (obs[17:2] !== fin) begin
            errors++;
            $display("FAIL wrap_down_final got %h exp %h", obs[17:2], fin);
        end
    endtask

    task automatic test_run_clear_same();
        do_clear();
        goto_count(123, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(i == 0, i == 0, 1'b0);
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL run_clear cyc %0d got %h exp %h", i, obs, e);
            end
        end
        checks++;
        if (obs[17:1] !== 17'h0) begin
            errors++;
            $display("FAIL run_clear_zero got %h exp %h", obs[17:1], 17'h0);
        end
    endtask

    task automatic test_mode_on_tick();
        int   k;
        logic r;
        logic m;
        do_clear();
        goto_count(5, 1'b0);
        k = -1;
        for (int n = 0; n < 40 && k < 5; n++) begin
            r = (n == 0) || (k == 4);
            m = 1'b0;
            if (k >= 0) begin
                k++;
            end else if (n > 0 && m_st == 1 && m_div == TD - 1) begin
                m = 1'b1;
                k = 0;
            end
            drive(r, 1'b0, m);
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL mode_tick n %0d got %h exp %h", n, obs, e);
            end
            if (k == 0 && m) begin
                checks++;
                if (obs[17:0] !== {16'h0006, 1'b1, 1'b1}) begin
                    errors++;
                    $display("FAIL mode_tick_up got %h exp %h", obs, {16'h0006, 2'b11});
                end
            end
            if (k == 4) begin
                checks++;
                if (obs[17:2] !== 16'h0005) begin
                    errors++;
                    $display("FAIL mode_tick_down got %h exp %h", obs[17:2], 16'h0005);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_clear();
        goto_count(42, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(i == 0, 1'b0, 1'b0);
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL rst_mid pre %0d got %h exp %h", i, obs, e);
            end
        end
        rst = 1'b1;
        #2;
        model_reset();
        checks++;
        if (obs !== 18'h0) begin
            errors++;
            $display("FAIL rst_mid_async got %h exp %h", obs, 18'h0);
        end
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) drive(i == 1, 1'b0, 1'b0);
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL rst_mid post %0d got %h exp %h", i, obs, e);
            end
            if (i == 4 || i == 5) begin
                checks++;
                if (obs[17:2] !== ((i == 5) ? 16'h0001 : 16'h0000)) begin
                    errors++;
                    $display("FAIL rst_mid_first_step %0d got %h", i, obs[17:2]);
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        btn_run   = 1'b0;
        btn_clear = 1'b0;
        btn_mode  = 1'b0;
        model_reset();
        test_reset();
        test_run_count();
        test_wrap_up();
        test_wrap_down();
        test_run_clear_same();
        test_mode_on_tick();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
